// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single unified instruction/data memory between the multicycle
// CPU and a host load/debug port. Every access walks the same fixed sequence
// IDLE -> ACCESS -> CAPTURE -> RESP, so an access always costs MEM_LAT+3
// cycles including the IDLE cycle in which the next request is sampled.
// Under contention the port that did not win last time is granted, which
// gives strict alternation when both ports keep requesting.
//
// Ports
//   clk, reset               clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata    CPU request (held until cpu_ack)
//   cpu_rdata, cpu_ack       CPU read data (held until next CPU read), done pulse
//   cpu_stall                cpu_req & ~cpu_ack, gates PC/IR/MDR enables
//   host_req/we/addr/wdata   host request (held until host_ack)
//   host_rdata, host_ack     host read data, done pulse
//   host_err                 pulses with host_ack for host_addr >= ADDR_LIMIT
//   mem_en, mem_we           one-cycle memory strobe and write qualifier
//   mem_addr, mem_wdata      registered address/data, held through the access
//   mem_rdata                memory read data, valid MEM_LAT cycles after mem_en
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                MEM_LAT    = 1,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT = 32'h0000_0400
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,

    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ack,
    output logic              host_err,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_CAPTURE,
        S_RESP
    } state_t;

    typedef enum logic {
        P_CPU,
        P_HOST
    } port_t;

    // Counter load value: CAPTURE lasts MEM_LAT cycles, the last of which
    // (counter == 0) is the one where mem_rdata is valid.
    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    state_t            r_state;
    port_t             r_owner;
    port_t             r_last_grant;
    logic [2:0]        r_cnt;

    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic [DATA_W-1:0] r_cpu_rdata;
    logic              r_cpu_ack;
    logic [DATA_W-1:0] r_host_rdata;
    logic              r_host_ack;
    logic              r_host_err;

    logic              w_cpu_pick;
    logic              w_host_pick;
    logic              w_host_illegal;

    // Arbitration: a lone requester wins; on a tie the port that was not
    // granted last time wins.
    always_comb begin
        w_cpu_pick     = cpu_req & (~host_req | (r_last_grant == P_HOST));
        w_host_pick    = host_req & ~w_cpu_pick;
        w_host_illegal = (host_addr >= ADDR_LIMIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_owner      <= P_CPU;
            r_last_grant <= P_HOST;
            r_cnt        <= 3'd0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_cpu_rdata  <= '0;
            r_cpu_ack    <= 1'b0;
            r_host_rdata <= '0;
            r_host_ack   <= 1'b0;
            r_host_err   <= 1'b0;
        end else begin
            // Strobes and acks are single-cycle pulses.
            r_mem_en   <= 1'b0;
            r_cpu_ack  <= 1'b0;
            r_host_ack <= 1'b0;
            r_host_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_cpu_pick) begin
                        r_owner      <= P_CPU;
                        r_last_grant <= P_CPU;
                        r_mem_we     <= cpu_we;
                        r_mem_addr   <= cpu_addr;
                        r_mem_wdata  <= cpu_wdata;
                        r_mem_en     <= 1'b1;
                        r_state      <= S_ACCESS;
                    end else if (w_host_pick) begin
                        r_owner      <= P_HOST;
                        r_last_grant <= P_HOST;
                        if (w_host_illegal) begin
                            // Out-of-range host access never touches memory;
                            // it is answered with an error on the next cycle.
                            r_host_ack <= 1'b1;
                            r_host_err <= 1'b1;
                            r_state    <= S_RESP;
                        end else begin
                            r_mem_we    <= host_we;
                            r_mem_addr  <= host_addr;
                            r_mem_wdata <= host_wdata;
                            r_mem_en    <= 1'b1;
                            r_state     <= S_ACCESS;
                        end
                    end
                end

                S_ACCESS: begin
                    r_cnt   <= LAT_M1;
                    r_state <= S_CAPTURE;
                end

                S_CAPTURE: begin
                    if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end else begin
                        if (r_owner == P_CPU) begin
                            if (!r_mem_we) begin
                                r_cpu_rdata <= mem_rdata;
                            end
                            r_cpu_ack <= 1'b1;
                        end else begin
                            if (!r_mem_we) begin
                                r_host_rdata <= mem_rdata;
                            end
                            r_host_ack <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end
                end

                S_RESP: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_stall  = cpu_req & ~r_cpu_ack;
    assign cpu_rdata  = r_cpu_rdata;
    assign cpu_ack    = r_cpu_ack;
    assign host_rdata = r_host_rdata;
    assign host_ack   = r_host_ack;
    assign host_err   = r_host_err;
    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the processor's single unified instruction/data memory between the multicycle CPU and a host load/debug port. It sits between the DataPath memory interface (the CPU side, driven by MemRead/MemWrite with the IorD-selected address) and the memory array. It stalls the CPU while the host owns the memory and alternates fairly between the two ports under contention. Each access runs through a fixed request/grant/access/response sequence.

## Interface
- ADDR_W, 32, address width (byte address; word aligned, bits [1:0] ignored)
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata (legal 1..7)
- ADDR_LIMIT, 32'h0000_0400, first illegal host byte address
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  captured read data, valid with cpu_ack, held until next CPU read
- cpu_ack  out  1  one-cycle completion pulse
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational); gates PC/IR/MDR enables
- host_req, host_we, host_addr, host_wdata  in  1/1/ADDR_W/DATA_W  host request, same rules as CPU
- host_rdata  out  DATA_W  host read data, valid with host_ack
- host_ack  out  1  one-cycle completion pulse
- host_err  out  1  pulses with host_ack when host_addr >= ADDR_LIMIT
- mem_en  out  1  one-cycle memory strobe
- mem_we  out  1  write qualifier, valid with mem_en
- mem_addr  out  ADDR_W  registered address, held from grant through the end of the access
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en

## Operation
- States: IDLE, ACCESS, CAPTURE, RESP. Owner register: CPU or HOST. last_grant register.
- IDLE: sample requests.
  - Only one port requests: grant that port.
  - Both request: grant the port that is not last_grant.
  - Host request with host_addr >= ADDR_LIMIT: go straight to RESP with no memory strobe.
  - On any grant: latch addr, we and wdata into the mem_* registers, set owner, update last_grant, go to ACCESS.
- ACCESS: assert mem_en for exactly one cycle. Load the wait counter with MEM_LAT-1 and go to CAPTURE.
- CAPTURE: hold while the counter is nonzero and decrement it each cycle.
  - When the counter is 0, mem_rdata is valid this cycle. Capture it into the owner's rdata register on reads only, then go to RESP.
- RESP: pulse the owner's ack (plus host_err for an illegal access), then return to IDLE.
- Writes follow the same sequence and timing as reads; rdata registers are left unchanged.
- A requester must drop or change req in the cycle after ack. A req still high in IDLE is a new request.
- A req that drops before ack is a protocol violation. The access still completes and ack still pulses.
- A request that arrives while another access is in flight waits. The pending port wins the next IDLE if the other port re-requests, because of last_grant.
- The stalled port's inputs are not sampled until its grant.

## Timing
- Reset values:
  - State IDLE; last_grant = HOST, so the CPU wins the first tie.
  - mem_en, mem_we, cpu_ack, host_ack, host_err = 0.
  - mem_addr, mem_wdata, cpu_rdata, host_rdata = 0.
  - Wait counter = 0.
- Latency: with req first seen in IDLE at cycle T:
  - mem_en is high at T+1.
  - Capture happens at T+MEM_LAT+1.
  - ack is high at T+MEM_LAT+2.
  - For MEM_LAT=1: ack at T+3.
- Illegal host access: ack and host_err at T+1, no mem_en.
- Throughput: one access per MEM_LAT+3 cycles, since there is at least one IDLE cycle between accesses.
- Reset asserted mid-access: immediate return to reset values.
  - No ack is issued for the aborted access.
  - A mem_en already issued is not retracted.
- mem_rdata is only sampled in CAPTURE; it is ignored in all other states.

## Test plan
- Single CPU read: MEM_LAT=1, mem[0x10]=0xDEADBEEF, cpu_req at T -> mem_en at T+1 with mem_addr=0x10, cpu_ack at T+3, cpu_rdata=0xDEADBEEF, cpu_stall high T..T+2.
- Host write then CPU read: host writes 0x12345678 to 0x20, then CPU reads 0x20 -> host_ack, then cpu_rdata=0x12345678. host_rdata is unchanged.
- Contention: both ports request continuously from reset -> grants alternate CPU, HOST, CPU, HOST. Acks are MEM_LAT+3 cycles apart.
- Illegal host address: host_addr=0x400 -> host_ack and host_err one cycle after the request, no mem_en pulse, memory unchanged.
- MEM_LAT=4: CPU read -> ack exactly 6 cycles after the request, and data is captured from the 4th cycle after mem_en.
- Reset in CAPTURE: assert reset two cycles after mem_en -> no ack, all outputs zero. A new CPU request after reset completes normally and wins any tie against the host.
